oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/nes_bus_pkg.sv | 21 ++
 rtl/oam_dma.sv | 161 ++++++++++++++++
 tb/tb_oam_dma.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_bus_pkg.sv
// ---------------------------------------------------------------------------
// nes_bus_pkg
// Shared definitions for blocks that master or snoop the NES CPU bus.
//   DMA_REG_ADDR_DEFAULT  : CPU write address that starts a sprite DMA
//   OAM_DATA_ADDR_DEFAULT : PPU OAM data port written by the DMA
//   dma_state_t           : OAM DMA sequencer states
// ---------------------------------------------------------------------------
package nes_bus_pkg;

    localparam logic [15:0] DMA_REG_ADDR_DEFAULT  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR_DEFAULT = 16'h2004;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_HALT,
        DMA_ALIGN,
        DMA_READ,
        DMA_WRITE
    } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma
// Sprite DMA engine. A CPU write to DMA_REG_ADDR latches a page number,
// halts the CPU, then copies 256 bytes from {page, 8'h00..8'hFF} to the
// OAM data port, one read cycle followed by one write cycle per byte.
// The bus multiplexer is inline: the CPU owns the bus except in READ/WRITE.
//
// Ports
//   clk_ph1    in   1  system clock, all state changes on rising edge
//   rst        in   1  asynchronous active-high reset
//   cpu_addr   in  16  CPU address bus
//   cpu_dout   in   8  CPU write data
//   cpu_r_nw   in   1  CPU read(1)/write(0)
//   bus_din    in   8  read data returned from the shared bus
//   rdy        out  1  CPU ready, low halts the CPU
//   addr_bus   out 16  muxed bus address
//   data_out   out  8  muxed bus write data
//   r_nw       out  1  muxed bus direction
//   dma_active out  1  high while the DMA owns the bus
//
// Build option
//   OAM_DMA_ALIGN_EN : when defined, a free-running parity flop forces every
//                      READ onto an even cycle, inserting one ALIGN cycle
//                      when needed (513 or 514 halted cycles). When not
//                      defined, HALT goes straight to READ (always 513).
// ---------------------------------------------------------------------------
module oam_dma
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEFAULT,
    parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEFAULT
) (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_r_nw,
    input  logic [7:0]  bus_din,
    output logic        rdy,
    output logic [15:0] addr_bus,
    output logic [7:0]  data_out,
    output logic        r_nw,
    output logic        dma_active
);

    dma_state_t state;
    dma_state_t state_next;

    logic [7:0] page;       // source page, high byte of every read address
    logic [7:0] cnt;        // byte index, low byte of every read address
    logic [7:0] data_byte;  // byte carried from READ to the following WRITE
    logic       trigger;
    logic       last_byte;

    // Only a write seen while idle starts a transfer; writes to the DMA
    // register during HALT/READ/WRITE are simply passed through and ignored.
    assign trigger   = (state == DMA_IDLE) && !cpu_r_nw && (cpu_addr == DMA_REG_ADDR);
    assign last_byte = (cnt == 8'hFF);

`ifdef OAM_DMA_ALIGN_EN
    logic parity;

    // Free-running even/odd cycle marker; READ may only occur with parity=0.
    always_ff @(posedge clk_ph1 or posedge rst) begin
        if (rst) begin
            parity <= 1'b0;
        end else begin
            parity <= ~parity;
        end
    end
`endif

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk_ph1 or posedge rst) begin
        if (rst) begin
            state <= DMA_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_ph1 or posedge rst) begin
        if (rst) begin
            page      <= 8'h00;
            cnt       <= 8'h00;
            data_byte <= 8'h00;
        end else begin
            if (trigger) begin
                page <= cpu_dout;
                cnt  <= 8'h00;
            end
            if (state == DMA_READ) begin
                data_byte <= bus_din;
            end
            if (state == DMA_WRITE) begin
                cnt <= cnt + 8'h01;
            end
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        rdy        = 1'b0;
        dma_active = 1'b0;
        addr_bus   = cpu_addr;
        data_out   = cpu_dout;
        r_nw       = cpu_r_nw;

        unique case (state)
            DMA_IDLE: begin
                rdy = 1'b1;
                if (trigger) begin
                    state_next = DMA_HALT;
                end
            end

            // The CPU only stops on a read cycle, so pending writes keep us
            // here; the first read cycle is the dummy cycle.
            DMA_HALT: begin
                if (cpu_r_nw) begin
`ifdef OAM_DMA_ALIGN_EN
                    // parity toggles at this edge: parity=1 now means the
                    // next cycle is even and READ may start immediately.
                    state_next = parity ? DMA_READ : DMA_ALIGN;
`else
                    state_next = DMA_READ;
`endif
                end
            end

`ifdef OAM_DMA_ALIGN_EN
            DMA_ALIGN: begin
                state_next = DMA_READ;
            end
`endif

            DMA_READ: begin
                dma_active = 1'b1;
                addr_bus   = {page, cnt};
                r_nw       = 1'b1;
                state_next = DMA_WRITE;
            end

            DMA_WRITE: begin
                dma_active = 1'b1;
                addr_bus   = OAM_DATA_ADDR;
                data_out   = data_byte;
                r_nw       = 1'b0;
                state_next = last_byte ? DMA_IDLE : DMA_READ;
            end

            default: begin
                state_next = DMA_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// ---------------------------------------------------------------------------
// tb_oam_dma
// Self-checking bench for oam_dma: reset state, an idle pass-through vector
// table, and hand-written transfer sequences (even/odd alignment, pending
// CPU writes, a full data pattern, reset in the middle of a transfer).
// Expected halt length follows OAM_DMA_ALIGN_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_oam_dma;

    logic        clk_ph1;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_r_nw;
    logic [7:0]  bus_din;
    logic        rdy;
    logic [15:0] addr_bus;
    logic [7:0]  data_out;
    logic        r_nw;
    logic        dma_active;

`ifdef OAM_DMA_ALIGN_EN
    localparam int ALIGN_EXTRA = 1;
`else
    localparam int ALIGN_EXTRA = 0;
`endif

    oam_dma dut (
        .clk_ph1    (clk_ph1),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_r_nw   (cpu_r_nw),
        .bus_din    (bus_din),
        .rdy        (rdy),
        .addr_bus   (addr_bus),
        .data_out   (data_out),
        .r_nw       (r_nw),
        .dma_active (dma_active)
    );

    initial clk_ph1 = 1'b0;
    always #5 clk_ph1 = ~clk_ph1;

    // Memory model: page 3 holds i^A5, every other page holds i+5A.
    function automatic logic [7:0] mem_val(input logic [7:0] pg, input logic [7:0] lo);
        return (pg == 8'h03) ? (lo ^ 8'hA5) : (lo + 8'h5A);
    endfunction

    assign bus_din = mem_val(addr_bus[15:8], addr_bus[7:0]);

    // Rising edges since reset release; mirrors the DUT's even/odd cycle.
    int edge_cnt;
    always @(posedge clk_ph1 or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  dout;
        logic        rnw;
        logic        exp_rdy;
        logic        exp_act;
        logic [15:0] exp_addr;
        logic [7:0]  exp_data;
        logic        exp_rnw;
    } vec_t;

    vec_t vecs[6];

    // Observations of one transfer
    logic [15:0] rd_q[$];
    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];
    int          halt_n;
    int          pre_n;
    bit          released;
    bit          rel_clean;

    // Called #1 after a rising edge. Optionally idles one cycle so the dummy
    // cycle lands on the requested parity, triggers, issues `pending` CPU
    // writes (to the DMA register, which must be ignored), then observes
    // until rdy returns or `stop_after` OAM writes have been seen.
    task automatic run_transfer(input logic [7:0] pg, input int pending,
                                input bit want_align, input int stop_after);
        bit noalign_now;
        rd_q.delete();
        wa_q.delete();
        wd_q.delete();
        halt_n    = 0;
        pre_n     = 0;
        released  = 1'b0;
        rel_clean = 1'b0;
        cpu_addr  = 16'h8000;
        cpu_r_nw  = 1'b1;
        cpu_dout  = 8'h00;
        noalign_now = (((edge_cnt + 1 + pending) % 2) == 1);
        if (noalign_now == want_align) begin
            @(posedge clk_ph1);
            #1;
        end
        cpu_addr = 16'h4014;
        cpu_r_nw = 1'b0;
        cpu_dout = pg;
        @(posedge clk_ph1);
        #1;
        for (int i = 0; i < pending; i++) begin
            cpu_addr = 16'h4014;
            cpu_dout = 8'hE7;
            cpu_r_nw = 1'b0;
            @(negedge clk_ph1);
            if (!rdy && !dma_active) pre_n++;
            check("pend_rdy", rdy, 1'b0);
            check("pend_active", dma_active, 1'b0);
            check("pend_addr", addr_bus, 16'h4014);
            check("pend_rnw", r_nw, 1'b0);
            @(posedge clk_ph1);
            #1;
        end
        cpu_addr = 16'h8000;
        cpu_r_nw = 1'b1;
        cpu_dout = 8'h00;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk_ph1);
            if (rdy) begin
                released  = 1'b1;
                rel_clean = !dma_active && (addr_bus == cpu_addr);
                break;
            end
            halt_n++;
            if (!dma_active) pre_n++;
            else if (r_nw) rd_q.push_back(addr_bus);
            else begin
                wa_q.push_back(addr_bus);
                wd_q.push_back(data_out);
            end
            if (stop_after > 0 && wa_q.size() >= stop_after) break;
        end
    endtask

    task automatic verify(input string tag, input logic [7:0] pg,
                          input int exp_halt, input int exp_pre);
        int bad_rd = 0;
        int bad_wr = 0;
        logic [15:0] first_rd;
        logic [15:0] last_wa;
        first_rd = (rd_q.size() > 0) ? rd_q[0] : 16'h0000;
        last_wa  = (wa_q.size() > 0) ? wa_q[wa_q.size()-1] : 16'h0000;
        check({tag, "_released"}, released, 1'b1);
        check({tag, "_halt_cycles"}, halt_n, exp_halt);
        check({tag, "_pre_dma_cycles"}, pre_n, exp_pre);
        check({tag, "_num_reads"}, rd_q.size(), 256);
        check({tag, "_num_writes"}, wa_q.size(), 256);
        check({tag, "_first_read"}, first_rd, {pg, 8'h00});
        check({tag, "_last_write_addr"}, last_wa, 16'h2004);
        for (int i = 0; i < rd_q.size(); i++) begin
            logic [7:0] ib;
            ib = 8'(i);
            if (rd_q[i] !== {pg, ib}) bad_rd++;
        end
        for (int i = 0; i < wa_q.size(); i++) begin
            logic [7:0] ib;
            ib = 8'(i);
            if (wa_q[i] !== 16'h2004 || wd_q[i] !== mem_val(pg, ib)) bad_wr++;
        end
        check({tag, "_read_seq_errs"}, bad_rd, 0);
        check({tag, "_write_seq_errs"}, bad_wr, 0);
        check({tag, "_release_clean"}, rel_clean, 1'b1);
        @(posedge clk_ph1);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Idle pass-through vectors: none of these may start a transfer.
        vecs[0] = '{16'h0000, 8'h11, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h11, 1'b1};
        vecs[1] = '{16'h4014, 8'h22, 1'b1, 1'b1, 1'b0, 16'h4014, 8'h22, 1'b1};
        vecs[2] = '{16'h4015, 8'h33, 1'b0, 1'b1, 1'b0, 16'h4015, 8'h33, 1'b0};
        vecs[3] = '{16'h4013, 8'h44, 1'b0, 1'b1, 1'b0, 16'h4013, 8'h44, 1'b0};
        vecs[4] = '{16'h2004, 8'h55, 1'b0, 1'b1, 1'b0, 16'h2004, 8'h55, 1'b0};
        vecs[5] = '{16'hFFFF, 8'h66, 1'b1, 1'b1, 1'b0, 16'hFFFF, 8'h66, 1'b1};

        // Reset state and pass-through while reset is held
        rst      = 1'b1;
        cpu_addr = 16'h1234;
        cpu_dout = 8'h9C;
        cpu_r_nw = 1'b1;
        #7;
        check("rst_rdy", rdy, 1'b1);
        check("rst_active", dma_active, 1'b0);
        check("rst_addr", addr_bus, 16'h1234);
        check("rst_data", data_out, 8'h9C);
        check("rst_rnw", r_nw, 1'b1);
        @(negedge clk_ph1);
        #2;
        rst = 1'b0;
        @(posedge clk_ph1);
        #1;

        for (int i = 0; i < 6; i++) begin
            cpu_addr = vecs[i].addr;
            cpu_dout = vecs[i].dout;
            cpu_r_nw = vecs[i].rnw;
            @(negedge clk_ph1);
            check($sformatf("vec%0d_rdy", i), rdy, vecs[i].exp_rdy);
            check($sformatf("vec%0d_active", i), dma_active, vecs[i].exp_act);
            check($sformatf("vec%0d_addr", i), addr_bus, vecs[i].exp_addr);
            check($sformatf("vec%0d_data", i), data_out, vecs[i].exp_data);
            check($sformatf("vec%0d_rnw", i), r_nw, vecs[i].exp_rnw);
            @(posedge clk_ph1);
            #1;
        end
        @(negedge clk_ph1);
        check("idle_hold_rdy", rdy, 1'b1);
        @(posedge clk_ph1);
        #1;

        // Page 2, no pending writes, READ lands on an even cycle
        run_transfer(8'h02, 0, 1'b0, 0);
        verify("even", 8'h02, 513, 1);

        // Page 2, odd alignment
        run_transfer(8'h02, 0, 1'b1, 0);
        verify("odd", 8'h02, 513 + ALIGN_EXTRA, 1 + ALIGN_EXTRA);

        // Two pending CPU writes (to the DMA register) before the dummy cycle
        run_transfer(8'h02, 2, 1'b0, 0);
        verify("pend", 8'h02, 513, 3);

        // Full data pattern from page 3
        run_transfer(8'h03, 0, 1'b0, 0);
        verify("pat", 8'h03, 513, 1);

        // Reset at byte 100, then a fresh transfer from page 3
        run_transfer(8'h03, 0, 1'b0, 100);
        check("mid_writes_before_rst", wa_q.size(), 100);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_rdy", rdy, 1'b1);
        check("mid_rst_active", dma_active, 1'b0);
        check("mid_rst_addr", addr_bus, cpu_addr);
        @(negedge clk_ph1);
        check("mid_rst_held_active", dma_active, 1'b0);
        #2;
        rst = 1'b0;
        @(negedge clk_ph1);
        check("post_rst_rdy", rdy, 1'b1);
        check("post_rst_active", dma_active, 1'b0);
        @(negedge clk_ph1);
        check("post_rst_idle_active", dma_active, 1'b0);
        @(posedge clk_ph1);
        #1;
        run_transfer(8'h03, 0, 1'b0, 0);
        verify("after_rst", 8'h03, 513, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
